// File: rtl/ball_engine_if.sv
// Signal bundle between the VGA timing stage / paddle logic and the ball
// engine. frame_pulse is a one-cycle strobe with no back-pressure: the engine
// acts on every cycle where it is high, and there is no ready path. The
// remaining inputs are level signals sampled every clock. The outputs are
// registered; state exposes the ball FSM for observation.
interface ball_engine_if;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       active;
  logic       frame_pulse;
  logic [9:0] paddle_x;
  logic       launch;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_pixel;
  logic       miss;
  logic [1:0] state;

  modport master (
    output hpos, vpos, active, frame_pulse, paddle_x, launch,
    input  ball_x, ball_y, ball_pixel, miss, state
  );

  modport slave (
    input  hpos, vpos, active, frame_pulse, paddle_x, launch,
    output ball_x, ball_y, ball_pixel, miss, state
  );
endinterface

// File: rtl/ball_engine.sv
// Breakout ball engine: serve / move / miss state machine, once-per-frame
// position stepping with wall and paddle bounces, and a registered per-pixel
// ball mask (one clock behind hpos/vpos).
module ball_engine #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_Y  = 456,
  parameter int PADDLE_W  = 64,
  parameter int SPEED     = 2,
  parameter int MISS_WAIT = 60
) (
  input logic          clk,
  input logic          nRst,
  ball_engine_if.slave bus
);

  localparam int CW = $clog2(MISS_WAIT);

  // All geometry is evaluated in 11 bits so sums never wrap.
  localparam logic [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] Y_REST    = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic [10:0] SERVE_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [10:0] STEP      = 11'(SPEED);
  localparam logic [10:0] SIZE      = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_W     = 11'(PADDLE_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(MISS_WAIT - 1);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_MOVE  = 2'd1,
    S_MISS  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          dx_neg_q, dx_neg_d;
  logic          dy_neg_q, dy_neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          miss_q, miss_d;
  logic          pixel_q, pixel_d;

  logic [10:0] x_w, y_w, px_w, h_w, v_w, serve_sum, serve_x;
  logic        paddle_hit;

  assign x_w  = {1'b0, x_q};
  assign y_w  = {2'b0, y_q};
  assign px_w = {1'b0, bus.paddle_x};
  assign h_w  = {1'b0, bus.hpos};
  assign v_w  = {2'b0, bus.vpos};

  assign serve_sum = px_w + SERVE_OFS;
  assign serve_x   = (serve_sum > X_MAX) ? X_MAX : serve_sum;

  // Paddle hit uses the pre-step position: the ball would cross the paddle
  // top this frame and horizontally overlaps the paddle.
  assign paddle_hit = (y_w < Y_REST) && (y_w + STEP >= Y_REST) &&
                      (x_w + SIZE > px_w) && (x_w < px_w + PAD_W);

  // Next-state, next-position and miss strobe; nothing moves without frame_pulse.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    cnt_d    = cnt_q;
    miss_d   = 1'b0;
    if (bus.frame_pulse) begin
      case (state_q)
        S_SERVE: begin
          x_d = serve_x[9:0];
          y_d = Y_REST[8:0];
          if (bus.launch) begin
            state_d  = S_MOVE;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b1;
          end
        end
        S_MOVE: begin
          if (!dx_neg_q) begin
            if (x_w + STEP >= X_MAX) begin
              x_d      = X_MAX[9:0];
              dx_neg_d = 1'b1;
            end else begin
              x_d = x_q + STEP[9:0];
            end
          end else if (x_w <= STEP) begin
            x_d      = 10'd0;
            dx_neg_d = 1'b0;
          end else begin
            x_d = x_q - STEP[9:0];
          end

          if (dy_neg_q) begin
            if (y_w <= STEP) begin
              y_d      = 9'd0;
              dy_neg_d = 1'b0;
            end else begin
              y_d = y_q - STEP[8:0];
            end
          end else if (paddle_hit) begin
            y_d      = Y_REST[8:0];
            dy_neg_d = 1'b1;
          end else if (y_w + STEP >= Y_MAX) begin
            y_d     = Y_MAX[8:0];
            miss_d  = 1'b1;
            state_d = S_MISS;
          end else begin
            y_d = y_q + STEP[8:0];
          end
        end
        S_MISS: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_SERVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_SERVE;
      endcase
    end
  end

  // Ball mask for the current pixel; hidden while waiting after a miss.
  always_comb begin
    pixel_d = bus.active && (state_q != S_MISS) &&
              (h_w >= x_w) && (h_w < x_w + SIZE) &&
              (v_w >= y_w) && (v_w < y_w + SIZE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q  <= S_SERVE;
      x_q      <= 10'((SCREEN_W - BALL_SIZE) / 2);
      y_q      <= Y_REST[8:0];
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b1;
      cnt_q    <= '0;
      miss_q   <= 1'b0;
      pixel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      pixel_q  <= pixel_d;
    end
  end

  assign bus.ball_x     = x_q;
  assign bus.ball_y     = y_q;
  assign bus.ball_pixel = pixel_q;
  assign bus.miss       = miss_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: a frame-level reference model predicts the
// ball after every frame_pulse and a pixel predictor covers the mask; both
// feed expectation queues that are drained when the DUT output is sampled.
module tb_ball_engine;

  localparam int ST_SERVE = 0;
  localparam int ST_MOVE  = 1;
  localparam int ST_MISS  = 2;

  logic clk;
  logic nRst;
  int   checks;
  int   errors;

  ball_engine_if bus();

  ball_engine dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {state[1:0], x[9:0], y[8:0], miss} per frame, and mask bits.
  logic [21:0] exp_q[$];
  logic [0:0]  pix_q[$];

  // Reference model of the ball after each frame.
  int m_state, m_x, m_y, m_cnt;
  bit m_dxn, m_dyn, m_miss;

  task automatic model_reset();
    m_state = ST_SERVE; m_x = 316; m_y = 448;
    m_dxn = 1'b0; m_dyn = 1'b1; m_cnt = 0; m_miss = 1'b0;
  endtask

  task automatic model_step(input int px, input bit ln);
    int ox, oy, t;
    m_miss = 1'b0;
    ox = m_x; oy = m_y;
    if (m_state == ST_SERVE) begin
      t = px + 28;
      m_x = (t > 632) ? 632 : t;
      m_y = 448;
      if (ln) begin m_state = ST_MOVE; m_dxn = 1'b0; m_dyn = 1'b1; end
    end else if (m_state == ST_MOVE) begin
      if (!m_dxn) begin
        if (ox + 2 >= 632) begin m_x = 632; m_dxn = 1'b1; end
        else m_x = ox + 2;
      end else begin
        if (ox <= 2) begin m_x = 0; m_dxn = 1'b0; end
        else m_x = ox - 2;
      end
      if (m_dyn) begin
        if (oy <= 2) begin m_y = 0; m_dyn = 1'b0; end
        else m_y = oy - 2;
      end else if (oy < 448 && oy + 2 >= 448 && ox + 8 > px && ox < px + 64) begin
        m_y = 448; m_dyn = 1'b1;
      end else if (oy + 2 >= 472) begin
        m_y = 472; m_miss = 1'b1; m_state = ST_MISS;
      end else begin
        m_y = oy + 2;
      end
    end else begin
      if (m_cnt == 59) begin m_state = ST_SERVE; m_cnt = 0; end
      else m_cnt++;
    end
  endtask

  function automatic bit model_pixel(input int h, input int v, input bit a);
    return a && (m_state != ST_MISS) && (h >= m_x) && (h < m_x + 8) &&
           (v >= m_y) && (v < m_y + 8);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: pulse, compare the scoreboard entry, then confirm miss drops.
  task automatic do_frame(input int px, input bit ln);
    logic [21:0] e;
    bus.paddle_x = 10'(px);
    bus.launch = ln;
    bus.frame_pulse = 1'b1;
    model_step(px, ln);
    exp_q.push_back({2'(m_state), 10'(m_x), 9'(m_y), m_miss});
    tick();
    bus.frame_pulse = 1'b0;
    bus.launch = 1'b0;
    e = exp_q.pop_front();
    check_val("frame_state", 32'(bus.state), 32'(e[21:20]));
    check_val("frame_x", 32'(bus.ball_x), 32'(e[19:10]));
    check_val("frame_y", 32'(bus.ball_y), 32'(e[9:1]));
    check_val("frame_miss", 32'(bus.miss), 32'(e[0]));
    tick();
    check_val("miss_one_cycle", 32'(bus.miss), 32'd0);
  endtask

  task automatic pixel_check(input string tag, input int h, input int v, input bit a);
    logic [0:0] e;
    bus.hpos = 10'(h);
    bus.vpos = 9'(v);
    bus.active = a;
    pix_q.push_back(model_pixel(h, v, a));
    tick();
    bus.active = 1'b0;
    e = pix_q.pop_front();
    check_val(tag, 32'(bus.ball_pixel), 32'(e));
  endtask

  function automatic int track(input int x);
    return (x >= 28) ? x - 28 : 0;
  endfunction

  function automatic int away(input int x);
    return (x < 300) ? 500 : 0;
  endfunction

  // Directed sequence.
  initial begin
    bit found;
    bit wall_next;
    checks = 0; errors = 0;
    nRst = 1'b0;
    bus.hpos = '0; bus.vpos = '0; bus.active = 1'b0;
    bus.frame_pulse = 1'b0; bus.paddle_x = '0; bus.launch = 1'b0;
    model_reset();
    tick(); tick();
    check_val("rst_x", 32'(bus.ball_x), 32'd316);
    check_val("rst_y", 32'(bus.ball_y), 32'd448);
    check_val("rst_pixel", 32'(bus.ball_pixel), 32'd0);
    check_val("rst_miss", 32'(bus.miss), 32'd0);
    check_val("rst_state", 32'(bus.state), ST_SERVE);
    nRst = 1'b1;
    tick();

    // Mask around the reset position (316,448).
    pixel_check("pix_origin", 316, 448, 1'b1);
    check_val("pix_origin_const", 32'(bus.ball_pixel), 32'd1);
    pixel_check("pix_right_edge", 324, 448, 1'b1);
    check_val("pix_right_edge_const", 32'(bus.ball_pixel), 32'd0);
    pixel_check("pix_inner_corner", 323, 455, 1'b1);
    pixel_check("pix_below", 316, 456, 1'b1);
    pixel_check("pix_left", 315, 450, 1'b1);
    pixel_check("pix_inactive", 316, 448, 1'b0);
    check_val("pix_inactive_const", 32'(bus.ball_pixel), 32'd0);
    for (int i = 0; i < 8; i++)
      pixel_check("pix_rand", $urandom_range(306, 330), $urandom_range(440, 462), 1'b1);

    // Serve snapping and clamp, then launch without a step.
    do_frame(100, 1'b0);
    check_val("serve_x", 32'(bus.ball_x), 32'd128);
    check_val("serve_y", 32'(bus.ball_y), 32'd448);
    do_frame(620, 1'b0);
    check_val("serve_clamp", 32'(bus.ball_x), 32'd632);
    do_frame(100, 1'b1);
    check_val("launch_state", 32'(bus.state), ST_MOVE);
    check_val("launch_no_step", 32'(bus.ball_y), 32'd448);
    for (int i = 0; i < 3; i++) do_frame(track(m_x), 1'b0);

    // Reset mid-move, with a frame pulse and a visible ball pixel pending.
    nRst = 1'b0;
    bus.frame_pulse = 1'b1;
    bus.active = 1'b1; bus.hpos = 10'(m_x); bus.vpos = 9'(m_y);
    tick();
    bus.frame_pulse = 1'b0;
    tick();
    model_reset();
    check_val("mid_rst_x", 32'(bus.ball_x), 32'd316);
    check_val("mid_rst_y", 32'(bus.ball_y), 32'd448);
    check_val("mid_rst_pixel", 32'(bus.ball_pixel), 32'd0);
    check_val("mid_rst_state", 32'(bus.state), ST_SERVE);
    bus.active = 1'b0;
    nRst = 1'b1;
    tick();

    // Launch from x=288 with a tracking paddle: right wall then a top-left corner.
    do_frame(260, 1'b0);
    do_frame(260, 1'b1);
    found = 1'b0;
    wall_next = 1'b0;
    for (int f = 0; f < 1300 && !found; f++) begin
      bit wall_pre, corner_pre;
      wall_pre = (m_x == 630) && !m_dxn;
      corner_pre = (m_x <= 2) && (m_y <= 2) && m_dxn && m_dyn;
      if (f % 97 == 0)
        pixel_check("pix_move", m_x + $urandom_range(0, 9), m_y + $urandom_range(0, 9), 1'b1);
      do_frame(track(m_x), 1'b0);
      if (wall_next) begin
        check_val("wall_return", 32'(bus.ball_x), 32'd630);
        wall_next = 1'b0;
      end
      if (wall_pre) begin
        check_val("wall_clamp", 32'(bus.ball_x), 32'd632);
        wall_next = 1'b1;
      end
      if (corner_pre) begin
        check_val("corner_x", 32'(bus.ball_x), 32'd0);
        check_val("corner_y", 32'(bus.ball_y), 32'd0);
        do_frame(track(m_x), 1'b0);
        check_val("corner_next_x", 32'(bus.ball_x), 32'd2);
        check_val("corner_next_y", 32'(bus.ball_y), 32'd2);
        found = 1'b1;
      end
    end
    check_val("corner_reached", 32'(found), 32'd1);

    // Paddle bounce.
    found = 1'b0;
    for (int f = 0; f < 600 && !found; f++) begin
      bit hit_pre;
      hit_pre = (m_y == 446) && !m_dyn;
      do_frame(track(m_x), 1'b0);
      if (hit_pre) begin
        check_val("paddle_y", 32'(bus.ball_y), 32'd448);
        check_val("paddle_state", 32'(bus.state), ST_MOVE);
        found = 1'b1;
      end
    end
    check_val("paddle_reached", 32'(found), 32'd1);

    // Paddle moved away: ball falls through to the miss line.
    found = 1'b0;
    for (int f = 0; f < 700 && !found; f++) begin
      do_frame(away(m_x), 1'b0);
      if (m_state == ST_MISS) begin
        check_val("miss_y", 32'(bus.ball_y), 32'd472);
        found = 1'b1;
      end
    end
    check_val("miss_reached", 32'(found), 32'd1);

    // Hidden for the wait period; launch is ignored while waiting.
    for (int f = 0; f < 60; f++) begin
      pixel_check("pix_hidden", m_x + 3, m_y + 3, 1'b1);
      check_val("pix_hidden_const", 32'(bus.ball_pixel), 32'd0);
      do_frame(300, f[0]);
    end
    check_val("reserve_state", 32'(bus.state), ST_SERVE);
    pixel_check("pix_visible_again", m_x + 3, m_y + 3, 1'b1);
    do_frame(100, 1'b0);
    check_val("reserve_x", 32'(bus.ball_x), 32'd128);
    check_val("reserve_y", 32'(bus.ball_y), 32'd448);

    // Launch at the right clamp: first step bounces straight off the wall.
    do_frame(620, 1'b1);
    do_frame(620, 1'b0);
    check_val("launch_wall_x", 32'(bus.ball_x), 32'd632);
    do_frame(620, 1'b0);
    check_val("launch_wall_back", 32'(bus.ball_x), 32'd630);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
